uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 870, meaning clocks per serial bit (i_Clock freq / baud), legal range 4..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal range 5..9, sent LSB first.
REQ-003 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame, legal values 1 or 2.
REQ-004 SHALL have parameter PARITY_ODD, default 0, meaning 0 = even parity and 1 = odd parity; it is used only when UART_RX_PARITY_EN is defined.
REQ-005 SHALL have port i_Clock  input  1  sole clock; all logic is on its rising edge.
REQ-006 SHALL have port i_Reset  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port i_Rx_Serial  input  1  asynchronous serial line; idle state is high.
REQ-008 SHALL have port i_Rx_Rd  input  1  consumer read strobe for the held frame.
REQ-009 SHALL have port o_Rx_DV  output  1  level signal, high while a received frame is held.
REQ-010 SHALL have port o_Rx_Byte  output  DATA_BITS  held data.
REQ-011 SHALL have port o_Frame_Err  output  1  at least one stop bit of the held frame sampled low.
REQ-012 SHALL have port o_Parity_Err  output  1  parity mismatch on the held frame.
REQ-013 SHALL have port o_Overrun  output  1  sticky flag: a completed frame was discarded because o_Rx_DV was already high.
REQ-014 SHALL have port o_Busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL pass i_Rx_Serial through a 2-flop synchronizer; all decisions use the synchronized line (sync).
REQ-016 SHALL use a bit counter whose width is at least clog2(CLKS_PER_BIT) bits; it SHALL NOT wrap before reaching CLKS_PER_BIT-1.
REQ-017 SHALL implement the state machine IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
REQ-018 IDLE: SHALL move to START only on a sync falling edge (previous 1, current 0); a line held low SHALL NOT start a new frame.
REQ-019 START: SHALL sample at count (CLKS_PER_BIT-1)/2; sample 1 -> IDLE (glitch rejected, no output change); sample 0 -> DATA with counter cleared.
REQ-020 DATA: SHALL sample each bit at count CLKS_PER_BIT-1 into bit index 0..DATA_BITS-1; after the last bit it SHALL go to PARITY if compiled in, else to STOP.
REQ-021 STOP: SHALL sample STOP_BITS bits, each at count CLKS_PER_BIT-1; any low sample sets the frame-error result; after the final stop-bit sample it SHALL go directly to IDLE with no wait to the end of the bit.
REQ-022 Completion, when o_Rx_DV=0 or i_Rx_Rd=1 in the final-sample cycle: SHALL load o_Rx_Byte, o_Frame_Err and o_Parity_Err, and o_Rx_DV SHALL be 1 on the next cycle.
REQ-023 Completion while o_Rx_DV=1 and i_Rx_Rd=0: SHALL discard the new frame, leave held outputs unchanged and set o_Overrun.
REQ-024 i_Rx_Rd with o_Rx_DV=1 and no simultaneous completion: SHALL clear o_Rx_DV, o_Frame_Err, o_Parity_Err and o_Overrun on the next cycle; o_Rx_Byte is retained.
REQ-025 i_Rx_Rd with o_Rx_DV=0: SHALL be ignored.
REQ-026 Simultaneous i_Rx_Rd and completion: SHALL load the new frame, keep o_Rx_DV=1 and clear o_Overrun.
REQ-027 A frame with frame error SHALL still be delivered, with o_Frame_Err=1; a break (line held low) SHALL yield one frame of data 0 with o_Frame_Err=1 and no further frames until the line returns high.

Reset
REQ-028 i_Reset=1 SHALL force state IDLE, counters 0, synchronizer flops and edge-detect flop 1, and all outputs 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no output; after release, reception SHALL begin only on a new falling edge.

Configuration
REQ-030 With macro UART_RX_PARITY_EN defined: the PARITY state SHALL sample one bit at count CLKS_PER_BIT-1; mismatch (XOR of data and parity bit differs from PARITY_ODD) SHALL set the parity-error result.
REQ-031 Without UART_RX_PARITY_EN: the PARITY state and its logic SHALL be absent, o_Parity_Err SHALL be tied 0 and PARITY_ODD SHALL be ignored.

Verification (CLKS_PER_BIT=16, DATA_BITS=8, STOP_BITS=1 unless stated)
REQ-032 SHALL send 0xA5 with a valid frame -> o_Rx_DV=1, o_Rx_Byte=0xA5, both error flags 0; i_Rx_Rd -> o_Rx_DV=0 next cycle.
REQ-033 SHALL apply a low glitch of 5 clocks on an idle line -> o_Rx_DV stays 0 and o_Busy returns to 0 within 12 clocks.
REQ-034 SHALL send 0x3C with stop bit low -> o_Rx_Byte=0x3C, o_Frame_Err=1; with the line then held low for 40 bit times, no second frame is delivered.
REQ-035 SHALL send 0x11 then 0x22 with no i_Rx_Rd -> o_Rx_Byte=0x11, o_Overrun=1; with i_Rx_Rd pulsed in the 0x22 final-sample cycle instead -> o_Rx_Byte=0x22, o_Overrun=0.
REQ-036 With UART_RX_PARITY_EN, PARITY_ODD=0 -> 0x07 sent with parity 1 gives o_Parity_Err=0; sent with parity 0 it gives o_Parity_Err=1.
REQ-037 SHALL assert i_Reset in the middle of data bit 4 of 0xFF -> no o_Rx_DV; the next valid 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg -- configurable UART receiver with a one-frame holding register.
//
// Optional feature macro: UART_RX_PARITY_EN (adds a parity bit after the data
// bits; without it o_Parity_Err is tied low and PARITY_ODD is ignored).
//
// Parameters
//   CLKS_PER_BIT  clocks per serial bit (4..65535)
//   DATA_BITS     data bits per frame, LSB first (5..9)
//   STOP_BITS     stop bits checked per frame (1 or 2)
//   PARITY_ODD    0 = even, 1 = odd parity (parity build only)
//
// Ports
//   i_Clock       clock, rising edge
//   i_Reset       synchronous active-high reset
//   i_Rx_Serial   asynchronous serial line, idle high
//   i_Rx_Rd       consumer read strobe for the held frame
//   o_Rx_DV       high while a received frame is held
//   o_Rx_Byte     held data
//   o_Frame_Err   a stop bit of the held frame was sampled low
//   o_Parity_Err  parity mismatch on the held frame
//   o_Overrun     sticky: a completed frame was dropped while o_Rx_DV was high
//   o_Busy        receiver is in any state other than IDLE
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 870,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    input  logic                 i_Rx_Rd,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Frame_Err,
    output logic                 o_Parity_Err,
    output logic                 o_Overrun,
    output logic                 o_Busy
);

    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [3:0]       BIT_LAST = 4'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    // Elaboration-time guard on the legal parameter ranges.
    generate
        if ((CLKS_PER_BIT < 4) || (CLKS_PER_BIT > 65535) ||
            (DATA_BITS < 5) || (DATA_BITS > 9) ||
            (STOP_BITS < 1) || (STOP_BITS > 2) ||
            (PARITY_ODD < 0) || (PARITY_ODD > 1)) begin : g_bad_param
            $error("uart_rx_cfg: parameter out of legal range");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
        , S_PARITY = 3'd4
`endif
    } state_t;

`ifdef UART_RX_PARITY_EN
    // True when data plus parity bit does not have the configured XOR value.
    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] data,
                                             input logic par_bit,
                                             input logic odd);
        return (((^data) ^ par_bit) != odd);
    endfunction
`endif

    state_t               r_state, w_state_nxt;
    logic                 r_sync_meta, r_sync, r_prev;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [3:0]           r_bit_idx, w_bit_idx_nxt;
    logic                 r_stop_idx, w_stop_idx_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                 r_ferr_acc, w_ferr_acc_nxt;
    logic                 w_done;
    logic                 w_fall;

    logic                 r_dv, w_dv_nxt;
    logic [DATA_BITS-1:0] r_byte, w_byte_nxt;
    logic                 r_ferr, w_ferr_nxt;
    logic                 r_ovr, w_ovr_nxt;
    logic                 r_busy;

`ifdef UART_RX_PARITY_EN
    logic                 r_perr_acc, w_perr_acc_nxt;
    logic                 r_perr, w_perr_nxt;
`endif

    // A frame may only begin on a real high-to-low transition of the synced line.
    assign w_fall = r_prev & ~r_sync;

    // Receive sequencer: next state, bit timing and sample capture.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_bit_idx_nxt  = r_bit_idx;
        w_stop_idx_nxt = r_stop_idx;
        w_shift_nxt    = r_shift;
        w_ferr_acc_nxt = r_ferr_acc;
        w_done         = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_perr_acc_nxt = r_perr_acc;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = CNT_ZERO;
                if (w_fall) begin
                    w_state_nxt    = S_START;
                    w_bit_idx_nxt  = 4'd0;
                    w_stop_idx_nxt = 1'b0;
                    w_ferr_acc_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
                    w_perr_acc_nxt = 1'b0;
`endif
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                // Mid-bit check: a high line here means the edge was a glitch.
                if (r_cnt == CNT_MID) begin
                    w_cnt_nxt = CNT_ZERO;
                    if (r_sync == 1'b0) begin
                        w_state_nxt = S_DATA;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = CNT_ZERO;
                    w_shift_nxt = {r_sync, r_shift[DATA_BITS-1:1]};
                    if (r_bit_idx == BIT_LAST) begin
                        w_bit_idx_nxt = 4'd0;
`ifdef UART_RX_PARITY_EN
                        w_state_nxt   = S_PARITY;
`else
                        w_state_nxt   = S_STOP;
`endif
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 4'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt      = CNT_ZERO;
                    w_perr_acc_nxt = parity_mismatch(r_shift, r_sync, 1'(PARITY_ODD));
                    w_state_nxt    = S_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
`endif
            S_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt      = CNT_ZERO;
                    w_ferr_acc_nxt = r_ferr_acc | ~r_sync;
                    // Leave on the last stop sample so a following start edge is not missed.
                    if (r_stop_idx == STOP_LAST) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_stop_idx_nxt = r_stop_idx + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // Holding register: load on completion, drop with overrun, clear on read.
    always_comb begin
        w_dv_nxt   = r_dv;
        w_byte_nxt = r_byte;
        w_ferr_nxt = r_ferr;
        w_ovr_nxt  = r_ovr;
`ifdef UART_RX_PARITY_EN
        w_perr_nxt = r_perr;
`endif
        if (w_done) begin
            if (!r_dv || i_Rx_Rd) begin
                w_dv_nxt   = 1'b1;
                w_byte_nxt = w_shift_nxt;
                w_ferr_nxt = w_ferr_acc_nxt;
`ifdef UART_RX_PARITY_EN
                w_perr_nxt = r_perr_acc;
`endif
                if (i_Rx_Rd) begin
                    w_ovr_nxt = 1'b0;
                end else begin
                    w_ovr_nxt = r_ovr;
                end
            end else begin
                w_ovr_nxt = 1'b1;
            end
        end else if (i_Rx_Rd && r_dv) begin
            w_dv_nxt   = 1'b0;
            w_ferr_nxt = 1'b0;
            w_ovr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
            w_perr_nxt = 1'b0;
`endif
        end else begin
            w_dv_nxt = r_dv;
        end
    end

    // State, synchronizer and output registers.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state     <= S_IDLE;
            r_sync_meta <= 1'b1;
            r_sync      <= 1'b1;
            r_prev      <= 1'b1;
            r_cnt       <= CNT_ZERO;
            r_bit_idx   <= 4'd0;
            r_stop_idx  <= 1'b0;
            r_shift     <= {DATA_BITS{1'b0}};
            r_ferr_acc  <= 1'b0;
            r_dv        <= 1'b0;
            r_byte      <= {DATA_BITS{1'b0}};
            r_ferr      <= 1'b0;
            r_ovr       <= 1'b0;
            r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr_acc  <= 1'b0;
            r_perr      <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_sync_meta <= i_Rx_Serial;
            r_sync      <= r_sync_meta;
            r_prev      <= r_sync;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_stop_idx  <= w_stop_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_ferr_acc  <= w_ferr_acc_nxt;
            r_dv        <= w_dv_nxt;
            r_byte      <= w_byte_nxt;
            r_ferr      <= w_ferr_nxt;
            r_ovr       <= w_ovr_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
`ifdef UART_RX_PARITY_EN
            r_perr_acc  <= w_perr_acc_nxt;
            r_perr      <= w_perr_nxt;
`endif
        end
    end

    assign o_Rx_DV     = r_dv;
    assign o_Rx_Byte   = r_byte;
    assign o_Frame_Err = r_ferr;
    assign o_Overrun   = r_ovr;
    assign o_Busy      = r_busy;
`ifdef UART_RX_PARITY_EN
    assign o_Parity_Err = r_perr;
`else
    assign o_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
`timescale 1ns/1ps
module tb_uart_rx_cfg;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rd;
    logic       dv;
    logic [7:0] byte_o;
    logic       fe;
    logic       pe;
    logic       ovr;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t sb[$];

    uart_rx_cfg #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8),
        .STOP_BITS   (1),
        .PARITY_ODD  (0)
    ) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Rx_Serial (rx),
        .i_Rx_Rd     (rd),
        .o_Rx_DV     (dv),
        .o_Rx_Byte   (byte_o),
        .o_Frame_Err (fe),
        .o_Parity_Err(pe),
        .o_Overrun   (ovr),
        .o_Busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one frame; optionally pulse the read strobe in the final stop-sample cycle.
    task automatic send_frame(input logic [7:0] d, input logic par,
                              input logic stop, input logic rd_final);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(CPB);
        end
        if (NPAR == 1) begin
            rx = par;
            tick(CPB);
        end
        rx = stop;
        for (int j = 0; j < CPB; j++) begin
            rd = rd_final && (j == 10);
            tick(1);
        end
        rd = 1'b0;
    endtask

    task automatic send_ok(input logic [7:0] d);
        exp_t e;
        e.d  = d;
        e.fe = 1'b0;
        e.pe = 1'b0;
        sb.push_back(e);
        send_frame(d, ^d, 1'b1, 1'b0);
    endtask

    task automatic check_frame(input string tag);
        exp_t e;
        for (int i = 0; i < 40 && dv !== 1'b1; i++) tick(1);
        chk({tag, "_dv"}, {31'd0, dv}, 32'd1);
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s_sb: observed frame 0x%0h expected no frame", tag, byte_o);
        end else begin
            e = sb.pop_front();
            chk({tag, "_byte"}, {24'd0, byte_o}, {24'd0, e.d});
            chk({tag, "_ferr"}, {31'd0, fe}, {31'd0, e.fe});
            chk({tag, "_perr"}, {31'd0, pe}, {31'd0, e.pe});
        end
    endtask

    task automatic read_pulse();
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
    endtask

    initial begin
        exp_t e;
        rx  = 1'b1;
        rd  = 1'b0;
        rst = 1'b1;
        tick(3);
        chk("rst_dv",   {31'd0, dv},     32'd0);
        chk("rst_byte", {24'd0, byte_o}, 32'd0);
        chk("rst_ferr", {31'd0, fe},     32'd0);
        chk("rst_perr", {31'd0, pe},     32'd0);
        chk("rst_ovr",  {31'd0, ovr},    32'd0);
        chk("rst_busy", {31'd0, busy},   32'd0);
        rst = 1'b0;
        tick(5);

        // Read strobe with nothing held is ignored.
        read_pulse();
        chk("rd_ignored", {31'd0, dv}, 32'd0);

        // Valid frame, then read clears valid and keeps the byte.
        send_ok(8'hA5);
        check_frame("a5");
        chk("a5_busy", {31'd0, busy}, 32'd0);
        read_pulse();
        chk("a5_rd_dv",   {31'd0, dv},     32'd0);
        chk("a5_retain",  {24'd0, byte_o}, 32'h0000_00A5);
        tick(8);

        // Short low glitch on the idle line.
        rx = 1'b0;
        tick(5);
        chk("glitch_busy", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        for (int i = 0; i < 12 && busy !== 1'b0; i++) tick(1);
        chk("glitch_idle", {31'd0, busy}, 32'd0);
        chk("glitch_dv",   {31'd0, dv},   32'd0);
        tick(20);

        // Stop bit low followed by a break of 40 bit times.
        e.d  = 8'h3C;
        e.fe = 1'b1;
        e.pe = 1'b0;
        sb.push_back(e);
        send_frame(8'h3C, ^(8'h3C), 1'b0, 1'b0);
        check_frame("3c");
        read_pulse();
        tick(40 * CPB);
        chk("break_dv",   {31'd0, dv},   32'd0);
        chk("break_busy", {31'd0, busy}, 32'd0);
        chk("break_ovr",  {31'd0, ovr},  32'd0);
        chk("break_ferr", {31'd0, fe},   32'd0);
        rx = 1'b1;
        tick(2 * CPB);
        chk("break_rel_dv", {31'd0, dv}, 32'd0);

        // Overrun: second frame dropped while first is held.
        send_ok(8'h11);
        send_frame(8'h22, ^(8'h22), 1'b1, 1'b0);
        check_frame("ovr1");
        chk("ovr1_flag", {31'd0, ovr}, 32'd1);
        read_pulse();
        chk("ovr1_clr_ovr", {31'd0, ovr}, 32'd0);
        chk("ovr1_clr_dv",  {31'd0, dv},  32'd0);

        // Read in the final-sample cycle loads the new frame and clears overrun.
        send_ok(8'h11);
        check_frame("ovr2_first");
        send_frame(8'h33, ^(8'h33), 1'b1, 1'b0);
        chk("ovr2_set", {31'd0, ovr}, 32'd1);
        e.d  = 8'h22;
        e.fe = 1'b0;
        e.pe = 1'b0;
        sb.push_back(e);
        send_frame(8'h22, ^(8'h22), 1'b1, 1'b1);
        check_frame("ovr2_simul");
        chk("ovr2_simul_ovr", {31'd0, ovr}, 32'd0);
        read_pulse();
        tick(4);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones.
        e.d  = 8'h07;
        e.fe = 1'b0;
        e.pe = 1'b0;
        sb.push_back(e);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        check_frame("par_ok");
        read_pulse();
        e.pe = 1'b1;
        sb.push_back(e);
        send_frame(8'h07, 1'b0, 1'b1, 1'b0);
        check_frame("par_bad");
        read_pulse();
        tick(4);
`endif

        // Reset in the middle of data bit 4 of 0xFF aborts the frame.
        rx = 1'b0;
        tick(CPB);
        rx = 1'b1;
        tick(4 * CPB + CPB / 2);
        rst = 1'b1;
        tick(2);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_dv",   {31'd0, dv},   32'd0);
        rst = 1'b0;
        tick(8 * CPB);
        chk("postrst_dv",   {31'd0, dv},   32'd0);
        chk("postrst_busy", {31'd0, busy}, 32'd0);
        send_ok(8'h5A);
        check_frame("5a");
        read_pulse();
        chk("5a_rd_dv", {31'd0, dv}, 32'd0);

        chk("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
